fetch_unit: RTL and testbench

//  IF stage of the 16-bit pipelined CPU. Owns the PC register: requests instructions from

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit_if_id_reg.sv | 34 +++
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the IF stage of the 16-bit pipelined CPU.
// Consumers pull everything in with import fetch_unit_pkg::*.
package fetch_unit_pkg;

    localparam int INSTR_W = 16;
    localparam logic [15:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2,
        HALTED  = 2'd3
    } fetch_state_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_JMP = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 4];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The fetch unit is the master; the memory (or a bench model) is the slave.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic               rd_en;
    logic [15:0]        addr;
    logic [INSTR_W-1:0] data;
    logic               valid;

    modport master (output rd_en, output addr, input data, input valid);
    modport slave  (input rd_en, input addr, output data, output valid);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise contents hold.
// The fall-through address is stored alongside the PC for the PC-control stage.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld,
    input  logic               flush,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [15:0]        d_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        pc,
    output logic [15:0]        pc_plus2
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            instr    <= '0;
            pc       <= '0;
            pc_plus2 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (ld) begin
            valid    <= 1'b1;
            instr    <= d_instr;
            pc       <= d_pc;
            pc_plus2 <= d_pc + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, imem request FSM and IF/ID load control.
// Optional build macro FETCH_PERF_CNT_EN adds a saturating fetch_cnt output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = OP_HLT
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int          CNT_W    = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [15:0]        next_pc,
    input  logic               stall,
    fetch_unit_if.master       imem,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [15:0]        if_pc,
    output logic [15:0]        if_pc_plus2,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   fetch_cnt
`endif
);

    fetch_state_t       state_reg, state_next;
    logic [15:0]        pc_reg, pc_next;
    logic [INSTR_W-1:0] buf_reg, buf_next;
    logic               ld, flush;
    logic [INSTR_W-1:0] ld_instr;
    logic [15:0]        target;
    logic               unused_next_pc_lsb;

    assign target             = {next_pc[15:1], 1'b0};
    assign unused_next_pc_lsb = next_pc[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            buf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            buf_reg   <= buf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        buf_next   = buf_reg;
        ld         = 1'b0;
        flush      = 1'b0;
        ld_instr   = imem.data;
        case (state_reg)
            FETCH: begin
                if (redirect) begin
                    // A request still in flight must be drained before refetching.
                    pc_next = target;
                    flush   = 1'b1;
                    if (!imem.valid) state_next = DISCARD;
                end else if (imem.valid) begin
                    if (!stall) begin
                        ld = 1'b1;
                        if (opcode_of(imem.data) == HALT_OP) state_next = HALTED;
                        else                                 pc_next    = pc_reg + PC_STEP;
                    end else begin
                        buf_next   = imem.data;
                        state_next = HOLD;
                    end
                end else if (!stall) begin
                    flush = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    flush      = 1'b1;
                    state_next = FETCH;
                end else if (!stall) begin
                    ld       = 1'b1;
                    ld_instr = buf_reg;
                    if (opcode_of(buf_reg) == HALT_OP) begin
                        state_next = HALTED;
                    end else begin
                        pc_next    = pc_reg + PC_STEP;
                        state_next = FETCH;
                    end
                end
            end
            DISCARD: begin
                flush = 1'b1;
                if (redirect)   pc_next    = target;
                if (imem.valid) state_next = FETCH;
            end
            HALTED: begin
                if (!stall) flush = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    assign imem.rd_en = rst_n && (state_reg == FETCH);
    assign imem.addr  = pc_reg;
    assign halted     = (state_reg == HALTED);

    if_id_reg u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .flush    (flush),
        .d_instr  (ld_instr),
        .d_pc     (pc_reg),
        .valid    (if_valid),
        .instr    (if_instr),
        .pc       (if_pc),
        .pc_plus2 (if_pc_plus2)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                      fetch_cnt <= '0;
        else if (ld && fetch_cnt != '1)  fetch_cnt <= fetch_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable imem model.
// Word at address a is {4'h1, a[11:0]}, except halt_addr which reads 16'hF000.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] next_pc = '0;
    logic        stall = 1'b0;
    logic        if_valid, halted;
    logic [15:0] if_instr, if_pc, if_pc_plus2;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
`endif

    int          n_assert = 0;
    int          n_fail = 0;
    int          lat = 0;
    logic [15:0] halt_addr = 16'hFFFF;

    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_req_addr = '0;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .next_pc     (next_pc),
        .stall       (stall),
        .imem        (imem),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [15:0] a, input logic [15:0] h);
        return (a == h) ? 16'hF000 : {4'h1, a[11:0]};
    endfunction

    // lat==0: response in the same cycle as the request; otherwise lat cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_busy <= 1'b0;
            mem_cnt  <= 0;
        end else if (lat != 0) begin
            if (mem_busy) begin
                if (mem_cnt == 0) mem_busy <= 1'b0;
                else              mem_cnt  <= mem_cnt - 1;
            end else if (imem.rd_en) begin
                mem_busy     <= 1'b1;
                mem_cnt      <= lat - 1;
                mem_req_addr <= imem.addr;
            end
        end
    end

    always_comb begin
        if (lat == 0) begin
            imem.valid = imem.rd_en;
            imem.data  = word(imem.addr, halt_addr);
        end else begin
            imem.valid = mem_busy && (mem_cnt == 0);
            imem.data  = word(mem_req_addr, halt_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        $display("[%0t] %s obs=%h exp=%h", $time, tag, obs, exp);
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_if_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!if_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 16'(if_valid), 16'd1);
    endtask

    initial begin
        // Reset state and back-to-back fetch with single-cycle memory
        lat = 0;
        do_reset();
        check("rst_if_valid", 16'(if_valid), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_rd_en", 16'(imem.rd_en), 16'd0);
        check("rst_addr", imem.addr, 16'h0000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("seq_pc%0d", i), if_pc, 16'(2 * i));
            check($sformatf("seq_valid%0d", i), 16'(if_valid), 16'd1);
        end
        check("seq_instr3", if_instr, 16'h1006);
        check("seq_plus2", if_pc_plus2, 16'h0008);
`ifdef FETCH_PERF_CNT_EN
        check("perf_cnt", fetch_cnt, 16'd4);
`endif

        // Redirect while a response is present: target aligned, IF/ID flushed
        redirect = 1'b1;
        next_pc  = 16'h0041;
        tick();
        redirect = 1'b0;
        check("redir_addr", imem.addr, 16'h0040);
        check("redir_flush", 16'(if_valid), 16'd0);
        check("redir_rd_en", 16'(imem.rd_en), 16'd1);
        tick();
        check("redir_pc", if_pc, 16'h0040);
        check("redir_instr", if_instr, 16'h1040);

        // Redirect with a 3-cycle memory request in flight
        lat = 3;
        do_reset();
        rst_n = 1'b1;
        tick();
        redirect = 1'b1;
        next_pc  = 16'h0080;
        tick();
        redirect = 1'b0;
        check("disc_rd_en", 16'(imem.rd_en), 16'd0);
        check("disc_addr", imem.addr, 16'h0080);
        check("disc_valid", 16'(if_valid), 16'd0);
        wait_if_valid("disc_wait", 12);
        check("disc_pc", if_pc, 16'h0080);
        check("disc_instr", if_instr, 16'h1080);

        // Stall held for three cycles while a response arrives
        lat = 0;
        do_reset();
        rst_n = 1'b1;
        tick();
        check("stall_first", if_pc, 16'h0000);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc%0d", i), if_pc, 16'h0000);
            check($sformatf("stall_instr%0d", i), if_instr, 16'h1000);
            check($sformatf("stall_rd_en%0d", i), 16'(imem.rd_en), 16'd0);
        end
        stall = 1'b0;
        tick();
        check("stall_rel_pc", if_pc, 16'h0002);
        check("stall_rel_instr", if_instr, 16'h1002);
        check("stall_rel_valid", 16'(if_valid), 16'd1);
        tick();
        check("stall_next_pc", if_pc, 16'h0004);

        // HLT at 0x0010
        halt_addr = 16'h0010;
        do_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("hlt_halted", 16'(halted), 16'd1);
        check("hlt_rd_en", 16'(imem.rd_en), 16'd0);
        check("hlt_addr", imem.addr, 16'h0010);
        check("hlt_instr", if_instr, 16'hF000);
        check("hlt_valid", 16'(if_valid), 16'd1);
        tick();
        check("hlt_drain", 16'(if_valid), 16'd0);
        redirect = 1'b1;
        next_pc  = 16'h0100;
        tick();
        redirect = 1'b0;
        check("hlt_redir_addr", imem.addr, 16'h0010);
        check("hlt_redir_halted", 16'(halted), 16'd1);

        // PC wrap from 0xFFFE
        halt_addr = 16'hFFFF;
        do_reset();
        rst_n    = 1'b1;
        redirect = 1'b1;
        next_pc  = 16'hFFFE;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_pc", if_pc, 16'hFFFE);
        check("wrap_plus2", if_pc_plus2, 16'h0000);
        check("wrap_addr", imem.addr, 16'h0000);
        tick();
        check("wrap_next", if_pc, 16'h0000);

        // Reset while a slow request is outstanding
        lat = 3;
        tick();
        check("mid_bubble", 16'(if_valid), 16'd0);
        tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_addr", imem.addr, 16'h0000);
        check("mid_rst_rd_en", 16'(imem.rd_en), 16'd0);
        check("mid_rst_valid", 16'(if_valid), 16'd0);
        rst_n = 1'b1;
        wait_if_valid("mid_wait", 12);
        check("mid_pc", if_pc, 16'h0000);
        check("mid_instr", if_instr, 16'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
